// File: rtl/display_bcd_driver.sv
// Sequential shift-add-3 binary-to-BCD converter feeding a 4-digit 7-segment controller.
// Define LEAD_ZERO_BLANK_EN to blank leading zero digits through nums_enable.
module display_bcd_driver #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value,
  input  logic             load,
  output logic [3:0]       num0,
  output logic [3:0]       num1,
  output logic [3:0]       num2,
  output logic [3:0]       num3,
  output logic [3:0]       nums_enable,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_e;

  localparam int CW = $clog2(WIDTH + 1);
`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [3:0] EN_RESET = 4'b0001;
`else
  localparam logic [3:0] EN_RESET = 4'b1111;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [15:0]      scratch_q, scratch_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [15:0]      digits_q, digits_d;
  logic [3:0]       en_q, en_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      digits_q  <= '0;
      en_q      <= EN_RESET;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      digits_q  <= digits_d;
      en_q      <= en_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    logic [15:0] adj;
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    digits_d  = digits_q;
    en_d      = en_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    adj       = scratch_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          scratch_d = '0;
          cnt_d     = CW'(WIDTH);
          state_d   = SHIFT;
          // Values beyond four digits are clamped so the display reads 9999.
          if (32'(value) > 32'd9999) begin
            bin_d  = WIDTH'(9999);
            pend_d = 1'b1;
          end else begin
            bin_d  = value;
            pend_d = 1'b0;
          end
        end
      end
      SHIFT: begin
        for (int i = 0; i < 4; i++) begin
          if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
        scratch_d = {adj[14:0], bin_q[WIDTH-1]};
        bin_d     = bin_q << 1;
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = UPDATE;
      end
      UPDATE: begin
        digits_d = scratch_q;
        ovf_d    = pend_q;
        done_d   = 1'b1;
        state_d  = IDLE;
`ifdef LEAD_ZERO_BLANK_EN
        en_d[3] = |scratch_q[15:12];
        en_d[2] = |scratch_q[15:8];
        en_d[1] = |scratch_q[15:4];
        en_d[0] = 1'b1;
`else
        en_d    = 4'b1111;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign num0        = digits_q[3:0];
  assign num1        = digits_q[7:4];
  assign num2        = digits_q[11:8];
  assign num3        = digits_q[15:12];
  assign nums_enable = en_q;
  assign ovf         = ovf_q;
  assign done        = done_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_display_bcd_driver.sv
// Self-checking bench for display_bcd_driver: table-driven conversions plus
// hand-written sequences for busy-time loads, done-cycle reloads and resets.
module tb_display_bcd_driver;

  localparam int WIDTH = 14;

  logic             clk = 1'b0;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] value;
  logic [3:0]       num0, num1, num2, num3, nums_enable;
  logic             busy, done, ovf;

  int assertCount = 0;
  int failCount   = 0;

  logic [15:0] prevDigits;
  logic        prevOvf;
  logic [3:0]  prevEn;

`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [3:0] RESET_EN = 4'b0001;
`else
  localparam logic [3:0] RESET_EN = 4'b1111;
`endif

  typedef struct {
    logic [WIDTH-1:0] val;
    logic [15:0]      expDigits;
    logic             expOvf;
    logic [3:0]       expBlankEn;
  } vector_t;

  vector_t vectors [10];

  display_bcd_driver #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .num0(num0), .num1(num1), .num2(num2), .num3(num3),
    .nums_enable(nums_enable), .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [3:0] selectEn(input logic [3:0] blankEn);
`ifdef LEAD_ZERO_BLANK_EN
    return blankEn;
`else
    return (blankEn == 4'b0000) ? 4'b1111 : 4'b1111;
`endif
  endfunction

  // Pulses load for one cycle, then waits for done while checking outputs hold steady.
  task automatic applyStimulus(input logic [WIDTH-1:0] v, output int latency, output bit holdOk);
    value = v;
    load  = 1'b1;
    tick();
    load    = 1'b0;
    latency = 1;
    holdOk  = 1'b1;
    while (!done && latency < 40) begin
      if ({num3, num2, num1, num0} !== prevDigits || ovf !== prevOvf ||
          nums_enable !== prevEn || busy !== 1'b1) holdOk = 1'b0;
      tick();
      latency++;
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " digits"}, 32'({num3, num2, num1, num0}), 32'h0);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " done"}, 32'(done), 32'd0);
    checkOutput({tag, " ovf"}, 32'(ovf), 32'd0);
    checkOutput({tag, " enable"}, 32'(nums_enable), 32'(RESET_EN));
  endtask

  initial begin
    int  latency;
    bit  holdOk;
    bit  sawDone;
    string tag;

    vectors[0] = '{14'd1234,  16'h1234, 1'b0, 4'b1111};
    vectors[1] = '{14'd7,     16'h0007, 1'b0, 4'b0001};
    vectors[2] = '{14'd0,     16'h0000, 1'b0, 4'b0001};
    vectors[3] = '{14'd1005,  16'h1005, 1'b0, 4'b1111};
    vectors[4] = '{14'd12000, 16'h9999, 1'b1, 4'b1111};
    vectors[5] = '{14'd42,    16'h0042, 1'b0, 4'b0011};
    vectors[6] = '{14'd9999,  16'h9999, 1'b0, 4'b1111};
    vectors[7] = '{14'd10000, 16'h9999, 1'b1, 4'b1111};
    vectors[8] = '{14'd16383, 16'h9999, 1'b1, 4'b1111};
    vectors[9] = '{14'd100,   16'h0100, 1'b0, 4'b0111};

    rst   = 1'b1;
    load  = 1'b0;
    value = '0;
    tick();
    tick();
    rst = 1'b0;
    checkReset("reset");
    prevDigits = 16'h0;
    prevOvf    = 1'b0;
    prevEn     = RESET_EN;

    for (int i = 0; i < 10; i++) begin
      tag = $sformatf("vec%0d(%0d)", i, vectors[i].val);
      applyStimulus(vectors[i].val, latency, holdOk);
      checkOutput({tag, " latency"}, 32'(latency), 32'd16);
      checkOutput({tag, " hold"}, 32'(holdOk), 32'd1);
      checkOutput({tag, " digits"}, 32'({num3, num2, num1, num0}), 32'(vectors[i].expDigits));
      checkOutput({tag, " ovf"}, 32'(ovf), 32'(vectors[i].expOvf));
      checkOutput({tag, " enable"}, 32'(nums_enable), 32'(selectEn(vectors[i].expBlankEn)));
      checkOutput({tag, " busy at done"}, 32'(busy), 32'd0);
      tick();
      checkOutput({tag, " done width"}, 32'(done), 32'd0);
      prevDigits = vectors[i].expDigits;
      prevOvf    = vectors[i].expOvf;
      prevEn     = selectEn(vectors[i].expBlankEn);
    end

    // Load during busy is ignored; the first value completes on schedule.
    value = 14'd5678;
    load  = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    value = 14'd1111;
    load  = 1'b1;
    tick();
    load    = 1'b0;
    latency = 4;
    while (!done && latency < 40) begin
      tick();
      latency++;
    end
    checkOutput("busyload latency", 32'(latency), 32'd16);
    checkOutput("busyload digits", 32'({num3, num2, num1, num0}), 32'h5678);

    // Load in the done cycle is accepted immediately.
    value = 14'd1111;
    load  = 1'b1;
    tick();
    load = 1'b0;
    checkOutput("doneload busy", 32'(busy), 32'd1);
    latency = 1;
    while (!done && latency < 40) begin
      tick();
      latency++;
    end
    checkOutput("doneload latency", 32'(latency), 32'd16);
    checkOutput("doneload digits", 32'({num3, num2, num1, num0}), 32'h1111);
    tick();

    // Reset mid-conversion aborts without a done pulse and clears the digits.
    value = 14'd4321;
    load  = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkReset("midreset");
    sawDone = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done) sawDone = 1'b1;
      tick();
    end
    checkOutput("midreset no done", 32'(sawDone), 32'd0);

    // Reset and load together: reset wins.
    value = 14'd77;
    load  = 1'b1;
    rst   = 1'b1;
    tick();
    rst  = 1'b0;
    load = 1'b0;
    checkOutput("rst+load busy", 32'(busy), 32'd0);
    tick();
    checkOutput("rst+load idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
